hazard_stall_unit: RTL and testbench

- Detects hazards that forwarding cannot cover and generates the pipeline stall, bubble and flush controls for the 5-stage MIPS datapath.
- Sits beside the forwarding unit.
- Drives the PC, IF/ID and ID/EX pipeline-register enables, so the EX/MEM/WB sources that forwarding relies on are valid when consumed.
- Holds a small FSM for the two-cycle branch-after-load stall, plus saturating hazard statistics counters.

---
 rtl/hazard_stall_unit_if.sv | 41 ++++
 rtl/hazard_stall_unit.sv | 90 +++++++++
 tb/tb_hazard_stall_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_unit_if.sv
// Hazard unit bundle: ID/EX/MEM operand and destination info in, pipeline holds, flush and statistics out.
// The pipeline (master) drives the stage fields and reads back the controls; the hazard unit is the slave.
interface hazard_stall_unit_if #(
    parameter int CW = 16
);
    logic [4:0]    ID_rs;
    logic [4:0]    ID_rt;
    logic          ID_use_rs;
    logic          ID_use_rt;
    logic          ID_branch;
    logic          ID_taken;
    logic [4:0]    EX_RW;
    logic          EX_regwe;
    logic          EX_memread;
    logic [4:0]    MEM_RW;
    logic          MEM_memread;
    logic          clr_counters;

    logic          PC_stall;
    logic          IFID_stall;
    logic          IDEX_bubble;
    logic          IFID_flush;
    logic [1:0]    stall_state;
    logic [CW-1:0] load_use_cnt;
    logic [CW-1:0] branch_stall_cnt;
    logic [CW-1:0] flush_cnt;

    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_branch, ID_taken,
               EX_RW, EX_regwe, EX_memread, MEM_RW, MEM_memread, clr_counters,
        input  PC_stall, IFID_stall, IDEX_bubble, IFID_flush, stall_state,
               load_use_cnt, branch_stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_branch, ID_taken,
               EX_RW, EX_regwe, EX_memread, MEM_RW, MEM_memread, clr_counters,
        output PC_stall, IFID_stall, IDEX_bubble, IFID_flush, stall_state,
               load_use_cnt, branch_stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush generation for hazards forwarding cannot cover, plus saturating hazard statistics.
// Controls are combinational in the same cycle, counters update on the next edge; no backpressure, stall is the hold.
module hazard_stall_unit #(
    parameter int CW = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_stall_unit_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        BR_WAIT2 = 2'b01
    } state_t;

    state_t state;

    logic m_ex_s, m_ex_t, m_mem_s, m_mem_t;
    logic m_ex, m_mem;
    logic h_lu, h_br1, h_br2;
    logic stall_raw, flush_raw, branch_cause;

    always_comb begin
        m_ex_s  = hz.ID_use_rs && (hz.ID_rs != 5'd0) && (hz.ID_rs == hz.EX_RW)  && hz.EX_regwe;
        m_ex_t  = hz.ID_use_rt && (hz.ID_rt != 5'd0) && (hz.ID_rt == hz.EX_RW)  && hz.EX_regwe;
        m_mem_s = hz.ID_use_rs && (hz.ID_rs != 5'd0) && (hz.ID_rs == hz.MEM_RW) && hz.MEM_memread;
        m_mem_t = hz.ID_use_rt && (hz.ID_rt != 5'd0) && (hz.ID_rt == hz.MEM_RW) && hz.MEM_memread;
        m_ex    = m_ex_s | m_ex_t;
        m_mem   = m_mem_s | m_mem_t;

        h_lu  = ~hz.ID_branch & hz.EX_memread & m_ex;
        h_br1 =  hz.ID_branch & ((~hz.EX_memread & m_ex) | m_mem);
        h_br2 =  hz.ID_branch & hz.EX_memread & m_ex;

        branch_cause = (state == BR_WAIT2) | h_br1 | h_br2;
        stall_raw    = branch_cause | h_lu;
        // The taken branch only squashes IF/ID on the cycle it actually leaves ID.
        flush_raw    = hz.ID_taken & ~stall_raw;
    end

    // Reset forces the controls low immediately, independent of the hazard inputs.
    assign hz.PC_stall    = stall_raw & ~rst;
    assign hz.IFID_stall  = stall_raw & ~rst;
    assign hz.IDEX_bubble = stall_raw & ~rst;
    assign hz.IFID_flush  = flush_raw & ~rst;
    assign hz.stall_state = state;

    // A load in EX feeding a branch needs two cycles; the second is owned by BR_WAIT2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (h_br2) state <= BR_WAIT2;
                BR_WAIT2: state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] load_use_q, branch_q, flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_use_q <= '0;
            branch_q   <= '0;
            flush_q    <= '0;
        end else if (hz.clr_counters) begin
            load_use_q <= '0;
            branch_q   <= '0;
            flush_q    <= '0;
        end else begin
            // Each stall cycle is charged to exactly one cause, branch taking precedence.
            if (stall_raw) begin
                if (branch_cause) begin
                    if (branch_q != CNT_MAX) branch_q <= branch_q + CNT_ONE;
                end else begin
                    if (load_use_q != CNT_MAX) load_use_q <= load_use_q + CNT_ONE;
                end
            end
            if (flush_raw && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_ONE;
        end
    end

    assign hz.load_use_cnt     = load_use_q;
    assign hz.branch_stall_cnt = branch_q;
    assign hz.flush_cnt        = flush_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomised and directed bench for hazard_stall_unit against a cause-based reference model.
module tb_hazard_stall_unit;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CW(CW)) hz ();

    hazard_stall_unit #(.CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: remaining forced branch-wait cycles and cause counters.
    int m_wait = 0;
    int m_lu   = 0;
    int m_br   = 0;
    int m_fl   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input bit use_f, input int r, input int w, input bit wen);
        return use_f && (r != 0) && (r == w) && wen;
    endfunction

    // Cause of the hazard in ID: 0 none, 1 load-use, 2 one-cycle branch, 3 two-cycle branch.
    function automatic int hazard_kind();
        bit ex_dep, mem_dep;
        ex_dep  = reads(hz.ID_use_rs, hz.ID_rs, hz.EX_RW, hz.EX_regwe) ||
                  reads(hz.ID_use_rt, hz.ID_rt, hz.EX_RW, hz.EX_regwe);
        mem_dep = reads(hz.ID_use_rs, hz.ID_rs, hz.MEM_RW, hz.MEM_memread) ||
                  reads(hz.ID_use_rt, hz.ID_rt, hz.MEM_RW, hz.MEM_memread);
        if (hz.ID_branch) begin
            if (ex_dep && hz.EX_memread) return 3;
            if (ex_dep || mem_dep)       return 2;
            return 0;
        end
        return (ex_dep && hz.EX_memread) ? 1 : 0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    task automatic clear_inputs();
        hz.ID_rs = 5'd0; hz.ID_rt = 5'd0; hz.ID_use_rs = 1'b0; hz.ID_use_rt = 1'b0;
        hz.ID_branch = 1'b0; hz.ID_taken = 1'b0;
        hz.EX_RW = 5'd0; hz.EX_regwe = 1'b0; hz.EX_memread = 1'b0;
        hz.MEM_RW = 5'd0; hz.MEM_memread = 1'b0; hz.clr_counters = 1'b0;
    endtask

    // Inputs are set just after a negedge; check controls, clock once, check registered state.
    task automatic cycle();
        int  k;
        bit  e_stall, e_flush;
        #1;
        k       = hazard_kind();
        e_stall = !rst && ((m_wait > 0) || (k != 0));
        e_flush = !rst && hz.ID_taken && !e_stall;
        check_val("PC_stall",    hz.PC_stall,    e_stall);
        check_val("IFID_stall",  hz.IFID_stall,  e_stall);
        check_val("IDEX_bubble", hz.IDEX_bubble, e_stall);
        check_val("IFID_flush",  hz.IFID_flush,  e_flush);
        @(posedge clk);
        if (!rst) begin
            if (hz.clr_counters) begin
                m_lu = 0; m_br = 0; m_fl = 0;
            end else begin
                if (e_stall) begin
                    if ((m_wait > 0) || (k >= 2)) m_br = sat_inc(m_br);
                    else                          m_lu = sat_inc(m_lu);
                end
                if (e_flush) m_fl = sat_inc(m_fl);
            end
            if (m_wait > 0)   m_wait = 0;
            else if (k == 3)  m_wait = 1;
        end
        #1;
        check_val("stall_state",      hz.stall_state,      (m_wait > 0) ? 1 : 0);
        check_val("load_use_cnt",     hz.load_use_cnt,     m_lu);
        check_val("branch_stall_cnt", hz.branch_stall_cnt, m_br);
        check_val("flush_cnt",        hz.flush_cnt,        m_fl);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        clear_inputs();
        hz.clr_counters = 1'b1;
        cycle();
        hz.clr_counters = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Load-use hazard present during reset: controls must still be held low.
        hz.EX_RW = 5'd8; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd8; hz.ID_use_rs = 1'b1; hz.ID_taken = 1'b1;
        @(negedge clk);
        cycle();
        check_val("rst_pc_stall", hz.PC_stall, 0);
        rst = 1'b0;
        clear_inputs();
        cycle();

        // Load-use: one stall cycle charged to load_use_cnt.
        clear_counts();
        hz.EX_RW = 5'd8; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd8; hz.ID_use_rs = 1'b1;
        cycle();
        check_val("lu_cnt_one", hz.load_use_cnt, 1);
        check_val("lu_state_run", hz.stall_state, 0);

        // Branch after ALU op: one stall, then taken flush.
        clear_counts();
        hz.EX_RW = 5'd9; hz.EX_regwe = 1'b1;
        hz.ID_rt = 5'd9; hz.ID_use_rt = 1'b1; hz.ID_branch = 1'b1; hz.ID_taken = 1'b1;
        cycle();
        hz.EX_RW = 5'd0; hz.EX_regwe = 1'b0;
        cycle();
        check_val("alu_br_flush_cnt", hz.flush_cnt, 1);
        check_val("alu_br_stall_cnt", hz.branch_stall_cnt, 1);

        // Branch after load: two stalls, flush only on the third cycle.
        clear_counts();
        hz.EX_RW = 5'd10; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd10; hz.ID_use_rs = 1'b1; hz.ID_branch = 1'b1; hz.ID_taken = 1'b1;
        cycle();
        check_val("ld_br_state_wait", hz.stall_state, 1);
        // Load has moved to MEM with memread dropped from EX; hazard terms clear but wait state holds.
        hz.EX_RW = 5'd0; hz.EX_regwe = 1'b0; hz.EX_memread = 1'b0;
        cycle();
        check_val("ld_br_flush_none", hz.flush_cnt, 0);
        cycle();
        check_val("ld_br_cnt_two", hz.branch_stall_cnt, 2);
        check_val("ld_br_lu_zero", hz.load_use_cnt, 0);
        check_val("ld_br_flush_one", hz.flush_cnt, 1);

        // Register 0 and unused operands never stall.
        clear_counts();
        hz.EX_RW = 5'd0; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd0; hz.ID_use_rs = 1'b1;
        cycle();
        hz.EX_RW = 5'd5; hz.ID_rs = 5'd5; hz.ID_use_rs = 1'b0;
        cycle();
        check_val("mask_lu_zero", hz.load_use_cnt, 0);

        // Saturation, then clear during a stall cycle.
        clear_counts();
        hz.EX_RW = 5'd8; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd8; hz.ID_use_rs = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check_val("sat_lu_15", hz.load_use_cnt, 15);
        hz.clr_counters = 1'b1;
        cycle();
        hz.clr_counters = 1'b0;
        check_val("clr_in_stall", hz.load_use_cnt, 0);

        // Reset while in BR_WAIT2 aborts the stall asynchronously.
        clear_inputs();
        hz.EX_RW = 5'd10; hz.EX_regwe = 1'b1; hz.EX_memread = 1'b1;
        hz.ID_rs = 5'd10; hz.ID_use_rs = 1'b1; hz.ID_branch = 1'b1; hz.ID_taken = 1'b1;
        cycle();
        check_val("pre_rst_wait", hz.stall_state, 1);
        #2 rst = 1'b1;
        #1;
        m_wait = 0; m_lu = 0; m_br = 0; m_fl = 0;
        check_val("arst_state",  hz.stall_state, 0);
        check_val("arst_pc",     hz.PC_stall,    0);
        check_val("arst_ifid",   hz.IFID_stall,  0);
        check_val("arst_bubble", hz.IDEX_bubble, 0);
        check_val("arst_flush",  hz.IFID_flush,  0);
        check_val("arst_brcnt",  hz.branch_stall_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        cycle();
        check_val("post_rst_stall", hz.PC_stall, 0);

        // Randomised traffic over a small register set to provoke frequent matches.
        for (int n = 0; n < 800; n++) begin
            hz.ID_rs       = 5'($urandom_range(0, 3));
            hz.ID_rt       = 5'($urandom_range(0, 3));
            hz.ID_use_rs   = 1'($urandom_range(0, 1));
            hz.ID_use_rt   = 1'($urandom_range(0, 1));
            hz.ID_branch   = 1'($urandom_range(0, 1));
            hz.ID_taken    = 1'($urandom_range(0, 1));
            hz.EX_RW       = 5'($urandom_range(0, 3));
            hz.EX_regwe    = 1'($urandom_range(0, 1));
            hz.EX_memread  = 1'($urandom_range(0, 1));
            hz.MEM_RW      = 5'($urandom_range(0, 3));
            hz.MEM_memread = 1'($urandom_range(0, 1));
            hz.clr_counters = ($urandom_range(0, 23) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
